// File: rtl/digitube_pkg.sv
// Shared constants and helpers for the scan-to-static display converter.
package digitube_pkg;

    // Segment field positions within one digit: {DP,CG,CF,CE,CD,CC,CB,CA}.
    localparam int unsigned SegCa = 0;
    localparam int unsigned SegCb = 1;
    localparam int unsigned SegCc = 2;
    localparam int unsigned SegCd = 3;
    localparam int unsigned SegCe = 4;
    localparam int unsigned SegCf = 5;
    localparam int unsigned SegCg = 6;
    localparam int unsigned SegDp = 7;

    // Widest supported anode vector for the helpers below.
    localparam int unsigned MaxDigits = 32;

    // Blank pattern in the low seg_w bits; callers take the slice they need.
    function automatic logic [63:0] blank(input int unsigned seg_w, input bit active_low);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (active_low && (i < seg_w)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [MaxDigits-1:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    // OR-encoder; only meaningful when is_onehot(v) holds.
    function automatic logic [4:0] onehot_index(input logic [MaxDigits-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MaxDigits; i++) begin
            if (v[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/digitube_stable_filter.sv
// Input register plus run-length stability filter. Comparing data_i against s0 is the same
// test as comparing s0 against the previous s0, one register earlier.
module digitube_stable_filter #(
    parameter int unsigned W          = 12,
    parameter int unsigned STABLE_CYC = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sample_o,
    output logic         accept_o,
    output logic         first_accept_o
);

    localparam int unsigned     CntW   = $clog2(STABLE_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);

    logic [W-1:0]    s0_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            same;

    always_comb begin
        same = (data_i == s0_q);
        if (!same) begin
            cnt_d = CntW'(1);
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        // First accepted cycle: saturation reached now, and not merely continuing a run.
        first_d = (cnt_d == CntMax) && !((cnt_q == CntMax) && same);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_q    <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            s0_q    <= data_i;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign sample_o       = s0_q;
    assign accept_o       = (cnt_q == CntMax);
    assign first_accept_o = first_q;

endmodule

// File: rtl/digitube_scan_hold.sv
// Converts a multiplexed anode/segment display bus into static per-digit segment outputs,
// with per-digit staleness timeout and multi-hot anode error reporting.
module digitube_scan_hold
    import digitube_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SEG_W          = 8,
    parameter int unsigned STABLE_CYC     = 3,
    parameter int unsigned TIMEOUT_CYC    = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_DIGITS+SEG_W-1:0] digi_in,
    input  logic                        clear,
    output logic [NUM_DIGITS*SEG_W-1:0] digi_out,
    output logic [NUM_DIGITS-1:0]       valid_mask,
    output logic                        anode_err
);

    localparam int unsigned    InW       = NUM_DIGITS + SEG_W;
    localparam logic [63:0]    BlankWide = blank(SEG_W, SEG_ACTIVE_LOW);
    localparam logic [SEG_W-1:0] Blank   = BlankWide[SEG_W-1:0];

    // A zero timeout keeps a 1-bit counter pinned at zero and never expires.
    localparam int unsigned    TmoW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned    TmoLastInt = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [TmoW-1:0] TmoMax    = TmoW'(TIMEOUT_CYC);
    localparam logic [TmoW-1:0] TmoLast   = TmoW'(TmoLastInt);
    localparam bit             TmoEn      = (TIMEOUT_CYC > 0);

    logic [InW-1:0]        sample;
    logic                  accept;
    logic                  first_accept;
    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      seg;
    logic [MaxDigits-1:0]  an_ext;
    logic                  an_onehot;
    logic [4:0]            an_idx;
    logic                  anode_err_q, anode_err_d;

    digitube_stable_filter #(
        .W          (InW),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk_i          (clk),
        .rst_ni         (reset_n),
        .data_i         (digi_in),
        .sample_o       (sample),
        .accept_o       (accept),
        .first_accept_o (first_accept)
    );

    always_comb begin
        an                    = sample[InW-1:SEG_W];
        seg                   = sample[SEG_W-1:0];
        an_ext                = '0;
        an_ext[NUM_DIGITS-1:0] = an;
        an_onehot             = is_onehot(an_ext);
        an_idx                = onehot_index(an_ext);
        // All-zero anodes are a normal blanking gap, not an error.
        anode_err_d           = accept && first_accept && (an != '0) && !an_onehot;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anode_err_q <= 1'b0;
        end else begin
            anode_err_q <= anode_err_d;
        end
    end

    assign anode_err = anode_err_q;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [SEG_W-1:0] hold_q, hold_d;
        logic             valid_q, valid_d;
        logic [TmoW-1:0]  tmo_q, tmo_d;
        logic             refresh;
        logic             expire;

        always_comb begin
            refresh = accept && an_onehot && (an_idx == 5'(i));
            expire  = TmoEn && (tmo_q == TmoLast);
            hold_d  = hold_q;
            valid_d = valid_q;
            tmo_d   = (tmo_q == TmoMax) ? tmo_q : tmo_q + TmoW'(1);
            // Priority: clear, then refresh, then timeout.
            if (clear) begin
                hold_d  = Blank;
                valid_d = 1'b0;
                tmo_d   = '0;
            end else if (refresh) begin
                hold_d  = seg;
                valid_d = 1'b1;
                tmo_d   = '0;
            end else if (expire) begin
                hold_d  = Blank;
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hold_q  <= Blank;
                valid_q <= 1'b0;
                tmo_q   <= '0;
            end else begin
                hold_q  <= hold_d;
                valid_q <= valid_d;
                tmo_q   <= tmo_d;
            end
        end

        assign digi_out[i*SEG_W +: SEG_W] = hold_q;
        assign valid_mask[i]              = valid_q;
    end

endmodule

// File: tb/tb_digitube_scan_hold.sv
// Directed bench: one instance with a 16-cycle timeout, one with the timeout disabled.
module tb_digitube_scan_hold;

    logic        clk;
    logic        reset_n;
    logic [11:0] digi_in;
    logic        clear;
    logic [31:0] out_a, out_b;
    logic [3:0]  valid_a, valid_b;
    logic        err_a, err_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          cycles;
        logic [31:0] exp_out;
        logic [3:0]  exp_valid;
    } vec_t;

    vec_t vecs[8];

    digitube_scan_hold #(
        .NUM_DIGITS     (4),
        .SEG_W          (8),
        .STABLE_CYC     (3),
        .TIMEOUT_CYC    (16),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digi_in    (digi_in),
        .clear      (clear),
        .digi_out   (out_a),
        .valid_mask (valid_a),
        .anode_err  (err_a)
    );

    digitube_scan_hold #(
        .NUM_DIGITS     (4),
        .SEG_W          (8),
        .STABLE_CYC     (3),
        .TIMEOUT_CYC    (0),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut_nt (
        .clk        (clk),
        .reset_n    (reset_n),
        .digi_in    (digi_in),
        .clear      (clear),
        .digi_out   (out_b),
        .valid_mask (valid_b),
        .anode_err  (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int bad;
        int err_cnt;
        int err_at;

        vecs[0] = '{4'h1, 8'hC0, 8, 32'hFFFF_FFC0, 4'h1};
        vecs[1] = '{4'h2, 8'hF9, 8, 32'hFFFF_F9C0, 4'h3};
        vecs[2] = '{4'h4, 8'hA4, 8, 32'hFFA4_F9C0, 4'h7};
        vecs[3] = '{4'h8, 8'hB0, 8, 32'hB0A4_F9C0, 4'hF};
        vecs[4] = '{4'h2, 8'h99, 2, 32'hB0A4_F9C0, 4'hF};
        vecs[5] = '{4'h0, 8'h00, 8, 32'hB0A4_F9C0, 4'hF};
        vecs[6] = '{4'h1, 8'h8E, 8, 32'hB0A4_F98E, 4'hF};
        vecs[7] = '{4'h0, 8'h00, 4, 32'hB0A4_F98E, 4'hF};

        reset_n = 1'b0;
        digi_in = '0;
        clear   = 1'b0;
        step(2);
        chk("reset_out_a", out_a, 32'hFFFF_FFFF);
        chk("reset_valid_a", 32'(valid_a), 32'h0);
        chk("reset_err_a", 32'(err_a), 32'h0);
        chk("reset_out_b", out_b, 32'hFFFF_FFFF);

        reset_n = 1'b1;
        step(2);

        // First write: held from edge 1, visible after edge 4.
        digi_in = 12'h1C0;
        step(3);
        chk("first_edge3_out", out_a, 32'hFFFF_FFFF);
        step(1);
        chk("first_edge4_out", out_a, 32'hFFFF_FFC0);
        chk("first_edge4_valid", 32'(valid_a), 32'h1);

        // Scan sweep, glitch and rewrite on the no-timeout instance.
        for (int i = 0; i < 8; i++) begin
            digi_in = {vecs[i].an, vecs[i].seg};
            step(vecs[i].cycles);
            chk($sformatf("vec%0d_out", i), out_b, vecs[i].exp_out);
            chk($sformatf("vec%0d_valid", i), 32'(valid_b), 32'(vecs[i].exp_valid));
        end

        // Single refresh at edge 4, blank exactly 16 edges later.
        digi_in = 12'h1C0;
        step(3);
        digi_in = 12'h000;
        step(1);
        chk("tmo_written", 32'(out_a[7:0]), 32'hC0);
        step(15);
        chk("tmo_edge19_seg", 32'(out_a[7:0]), 32'hC0);
        chk("tmo_edge19_valid", 32'(valid_a[0]), 32'h1);
        step(1);
        chk("tmo_edge20_seg", 32'(out_a[7:0]), 32'hFF);
        chk("tmo_edge20_valid", 32'(valid_a[0]), 32'h0);

        // Refresh every 10 cycles must never let digit 0 blank.
        digi_in = 12'h1C0;
        step(3);
        digi_in = 12'h000;
        step(7);
        bad = 0;
        for (int p = 0; p < 4; p++) begin
            for (int e = 0; e < 10; e++) begin
                digi_in = (e < 3) ? 12'h1C0 : 12'h000;
                step(1);
                if (out_a[7:0] !== 8'hC0 || valid_a[0] !== 1'b1) bad++;
            end
        end
        chk("refresh_no_blank", 32'(bad), 32'h0);

        // Multi-hot anodes stable for 6 cycles: one error pulse, no writes.
        err_cnt = 0;
        err_at  = 0;
        digi_in = 12'h300;
        for (int e = 1; e <= 10; e++) begin
            if (e == 7) digi_in = 12'h000;
            step(1);
            if (err_a === 1'b1) begin
                err_cnt++;
                err_at = e;
            end
        end
        chk("err_pulse_count", 32'(err_cnt), 32'd1);
        chk("err_pulse_edge", 32'(err_at), 32'd4);
        chk("err_no_write_out", out_b, 32'hB0A4_F9C0);
        chk("err_no_write_valid", 32'(valid_b), 32'hF);

        // Asynchronous reset mid-scan.
        digi_in = 12'h4A4;
        step(5);
        chk("pre_reset_valid", 32'(valid_b), 32'hF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out_b", out_b, 32'hFFFF_FFFF);
        chk("async_reset_valid_b", 32'(valid_b), 32'h0);
        chk("async_reset_out_a", out_a, 32'hFFFF_FFFF);
        chk("async_reset_valid_a", 32'(valid_a), 32'h0);
        step(1);
        reset_n = 1'b1;
        step(3);
        chk("post_reset_edge3", out_b, 32'hFFFF_FFFF);
        step(1);
        chk("post_reset_edge4_out", out_b, 32'hFFA4_FFFF);
        chk("post_reset_edge4_valid", 32'(valid_b), 32'h4);

        // Clear beats a same-cycle refresh, then the still-stable sample rewrites.
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_out", out_b, 32'hFFFF_FFFF);
        chk("clear_valid", 32'(valid_b), 32'h0);
        step(1);
        chk("clear_rewrite_out", out_b, 32'hFFA4_FFFF);
        chk("clear_rewrite_valid", 32'(valid_b), 32'h4);
        chk("clear_rewrite_out_a", out_a, 32'hFFA4_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digitube_scan_hold.md
Name: digitube_scan_hold

Overview:
- Parametrised scan-to-static display converter.
- Samples a time-multiplexed display bus: one-hot anode select plus shared segment lines.
- Applies a stability filter to each sample, then holds each digit's last segment pattern in a per-digit register, so unselected digits stay lit instead of blanking.
- Sits between the CPU's scanning display driver and a board with static per-digit 7-segment outputs. Adds a staleness timeout and error reporting for non-one-hot anode codes.

Parameters:
- NUM_DIGITS, 4, number of digits / anode lines.
- SEG_W, 8, segment bits per digit: {DP,CG,CF,CE,CD,CC,CB,CA}.
- STABLE_CYC, 3, consecutive identical samples required before a sample is accepted (>=1).
- TIMEOUT_CYC, 1024, cycles without refresh before a digit blanks; 0 disables the timeout.
- SEG_ACTIVE_LOW, 1, 1: blank = all ones; 0: blank = all zeros.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digi_in  in  NUM_DIGITS+SEG_W  {AN[NUM_DIGITS-1:0], SEG[SEG_W-1:0]}; AN is active-high one-hot.
- clear  in  1  synchronous; blanks all digits and clears valid_mask.
- digi_out  out  NUM_DIGITS*SEG_W  digit i at [i*SEG_W +: SEG_W]; registered.
- valid_mask  out  NUM_DIGITS  bit i = digit i refreshed within the timeout window.
- anode_err  out  1  one-cycle pulse when an accepted sample has more than one AN bit set.

Behaviour:
- Reset (async, reset_n=0):
  - digi_out = BLANK on all digits; valid_mask = 0; anode_err = 0.
  - Input register, stability counter and timeout counters = 0.
- Input stage: digi_in is registered into s0 every cycle; s1 holds the previous s0.
- Stability counter:
  - If s0 == s1, cnt increments, saturating at STABLE_CYC.
  - Otherwise cnt = 1.
  - A sample is "accepted" in any cycle with cnt == STABLE_CYC. With STABLE_CYC=1, every sample is accepted.
- Latency: digi_in held constant from before edge k is accepted at edge k+STABLE_CYC-1, and digi_out updates at edge k+STABLE_CYC.
- Accepted sample, AN one-hot at index i:
  - hold[i] <= SEG; valid_mask[i] <= 1; tmo[i] <= 0.
  - Rewritten every cycle while the sample stays accepted; this is the refresh.
- Accepted sample, AN == 0: no write, no error (inter-digit blanking gap).
- Accepted sample, AN multi-hot: no write. anode_err pulses exactly once per stable run, in the first accepted cycle only.
- Timeout (TIMEOUT_CYC>0):
  - Each tmo[i] increments every cycle, saturating at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC-1 without a refresh, the next edge sets hold[i] = BLANK and valid_mask[i] = 0.
  - A refresh and a timeout on the same digit in the same cycle: refresh wins.
- clear=1: all hold = BLANK, valid_mask = 0, tmo = 0, effective next edge.
  - clear outranks a refresh in the same cycle.
  - Filter state is not cleared, so a sample still stable after clear is rewritten on the following cycle.
- Reset asserted mid-run: all state returns to reset values immediately. After release, a full STABLE_CYC run is needed before any write.
- Widths:
  - Counters are sized $clog2(STABLE_CYC+1) and $clog2(TIMEOUT_CYC+1).
  - The index encoder is only used when the one-hot check passes.

Decomposition:
- Package digitube_pkg holds:
  - function blank(SEG_W, SEG_ACTIVE_LOW);
  - function is_onehot(vector);
  - function onehot_index(vector);
  - field-position constants for DP and CA..CG.
- Sub-module digitube_stable_filter (params W, STABLE_CYC) owns s0/s1/cnt and outputs {sample, accept, first_accept}.
- The top module holds the per-digit hold registers and timeout counters (generate loop).

Test Plan:
- Defaults with STABLE_CYC=3, TIMEOUT_CYC=16. Drive digi_in=12'b0001_1100_0000 from edge 1 -> digi_out[7:0]=8'hC0 after edge 4, valid_mask=4'b0001, other digits 8'hFF.
- Scan 4 digits with 8 cycles each (AN=0001,0010,0100,1000; SEG=C0,F9,A4,B0) -> digi_out=32'hB0A4F9C0 held after the first full sweep; valid_mask=4'hF.
- Glitch: AN=0010, SEG=8'h99 for 2 cycles, then AN=0 -> digi_out unchanged, no write.
- Digit 0 written once, then AN=0 held -> digi_out[7:0] returns to 8'hFF and valid_mask[0]=0 exactly 16 cycles after the last refresh. Digit 0 refreshed every 10 cycles -> never blanks.
- AN=0011 stable 6 cycles -> anode_err high for exactly 1 cycle (at the 3rd sample), no digit changes.
- Pull reset_n low mid-scan with valid_mask=4'hF -> all outputs 8'hFF and valid_mask=0 immediately. clear=1 in the same cycle as a refresh of digit 2 -> digit 2 blank for that edge and rewritten on the next.
